// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative MUL, DIVU and REMU,
// with valid/ready handshakes on both sides and registered result and flags.
module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      alu_ctrl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            z_flg,
    output logic            n_flg,
    output logic            c_flg,
    output logic            v_flg,
    output logic            err
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;
    localparam int MSB = XLEN - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1110;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    logic [1:0]      r_state;
    logic [3:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_res;
    logic            r_z;
    logic            r_n;
    logic            r_c;
    logic            r_v;
    logic            r_err;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_diff;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_sc_res;
    logic            w_sc_c;
    logic            w_sc_v;
    logic            w_sc_err;
    logic            w_is_mc;

    logic [XLEN-1:0] w_mul_acc;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_mc_res;
    logic [XLEN-1:0] w_wr_res;

    assign w_sum   = {1'b0, in1} + {1'b0, in2};
    assign w_diff  = {1'b0, in1} - {1'b0, in2};
    assign w_shamt = in2[SHW-1:0];
    assign w_is_mc = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU);

    always_comb begin
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        w_sc_err = 1'b0;
        case (alu_ctrl)
            OP_AND:  w_sc_res = in1 & in2;
            OP_OR:   w_sc_res = in1 | in2;
            OP_ADD: begin
                w_sc_res = w_sum[MSB:0];
                w_sc_c   = w_sum[XLEN];
                w_sc_v   = (in1[MSB] == in2[MSB]) && (w_sum[MSB] != in1[MSB]);
            end
            OP_SLL:  w_sc_res = in1 << w_shamt;
            OP_SUB: begin
                // Carry on subtract is no-borrow: set when in1 >= in2 unsigned.
                w_sc_res = w_diff[MSB:0];
                w_sc_c   = ~w_diff[XLEN];
                w_sc_v   = (in1[MSB] != in2[MSB]) && (w_diff[MSB] != in1[MSB]);
            end
            OP_SRL:  w_sc_res = in1 >> w_shamt;
            OP_XOR:  w_sc_res = in1 ^ in2;
            OP_SLT:  w_sc_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SRA:  w_sc_res = $unsigned($signed(in1) >>> w_shamt);
            OP_NOT:  w_sc_res = ~in1;
            OP_NOR:  w_sc_res = ~(in1 | in2);
            OP_SLTU: w_sc_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
            OP_ILL:  w_sc_err = 1'b1;
            default: w_sc_res = '0;
        endcase
    end

    // MUL: r_a is the left-shifting multiplicand, r_b the right-shifting multiplier.
    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

    // DIVU/REMU: r_a shifts the dividend out and the quotient in, r_acc is the remainder.
    // A zero divisor always passes the trial, giving all-ones quotient and remainder = in1.
    assign w_rem_sh   = {r_acc, r_a[MSB]};
    assign w_trial    = w_rem_sh - {1'b0, r_b};
    assign w_ge       = ~w_trial[XLEN];
    assign w_rem_next = w_ge ? w_trial[MSB:0] : w_rem_sh[MSB:0];
    assign w_quo_next = {r_a[MSB-1:0], w_ge};

    always_comb begin
        w_mc_res = w_rem_next;
        if (r_op == OP_MUL) begin
            w_mc_res = w_mul_acc;
        end else if (r_op == OP_DIVU) begin
            w_mc_res = w_quo_next;
        end
    end

    assign w_wr_res = (r_state == BUSY) ? w_mc_res : w_sc_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_err   <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op <= alu_ctrl;
                        if (w_is_mc) begin
                            r_a     <= in1;
                            r_b     <= in2;
                            r_acc   <= '0;
                            r_cnt   <= CW'(XLEN);
                            r_state <= BUSY;
                        end else begin
                            r_res   <= w_wr_res;
                            r_z     <= (w_wr_res == '0);
                            r_n     <= w_wr_res[MSB];
                            r_c     <= w_sc_c;
                            r_v     <= w_sc_v;
                            r_err   <= w_sc_err;
                            r_state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (r_op == OP_MUL) begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else begin
                        r_acc <= w_rem_next;
                        r_a   <= w_quo_next;
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_res   <= w_wr_res;
                        r_z     <= (w_wr_res == '0);
                        r_n     <= w_wr_res[MSB];
                        r_c     <= 1'b0;
                        r_v     <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign res       = r_res;
    assign z_flg     = r_z;
    assign n_flg     = r_n;
    assign c_flg     = r_c;
    assign v_flg     = r_v;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results queued at issue, compared at retire.
module tb_alu_mc;

    typedef logic [36:0] obs_t;  // {res, z, n, c, v, err}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [3:0]  alu_ctrl = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res;
    logic        z_flg, n_flg, c_flg, v_flg, err;

    int n_tests = 0;
    int n_fail  = 0;
    obs_t sb[$];

    alu_mc #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .alu_ctrl(alu_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .z_flg(z_flg), .n_flg(n_flg), .c_flg(c_flg), .v_flg(v_flg), .err(err)
    );

    always #5 clk = ~clk;

    function automatic obs_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c = 1'b0;
        logic        v = 1'b0;
        logic        e = 1'b0;
        longint      s;
        r = '0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h3: r = a << b[4:0];
            4'h4: begin
                r = a - b;
                c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h5: r = a >> b[4:0];
            4'h6: r = a * b;
            4'h7: r = a ^ b;
            4'h8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9: r = $signed(a) >>> b[4:0];
            4'hA: r = ~a;
            4'hB: r = ~(a | b);
            4'hC: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hD: r = (b == 0) ? a : a % b;
            4'hE: r = (a < b) ? 32'd1 : 32'd0;
            default: e = 1'b1;
        endcase
        return {r, (r == 0), r[31], c, v, e};
    endfunction

    // Drives one request into IDLE; returns at #1 after the accept edge, then scrambles inputs.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
        @(negedge clk);
        alu_ctrl = op;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        if (push) sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1      = $urandom;
        in2      = $urandom;
        alu_ctrl = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_out(output int lat, output obs_t obs, output bit rdy_seen);
        lat      = 1;
        rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 60) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        obs = {res, z_flg, n_flg, c_flg, v_flg, err};
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic obs_t pop_exp();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        #1;
        n_tests++;
        if ({in_ready, out_valid, res, z_flg, n_flg, c_flg, v_flg, err} !== {2'b10, 37'd0}) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b ov=%b res=%h flags=%b%b%b%b err=%b want rdy=1 ov=0 res=0 flags=0 err=0",
                     in_ready, out_valid, res, z_flg, n_flg, c_flg, v_flg, err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_idle got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
        end
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    task automatic test_single();
        vec_t vecs[15] = '{
            '{4'h2, 32'h7FFF_FFFF, 32'h0000_0001},
            '{4'h4, 32'h0000_0005, 32'h0000_0005},
            '{4'h8, 32'hFFFF_FFFF, 32'h0000_0001},
            '{4'hE, 32'hFFFF_FFFF, 32'h0000_0001},
            '{4'h9, 32'h8000_0000, 32'h0000_0004},
            '{4'h2, 32'hFFFF_FFFF, 32'h0000_0001},
            '{4'h4, 32'h0000_0003, 32'h0000_0005},
            '{4'h4, 32'h8000_0000, 32'h0000_0001},
            '{4'h0, 32'hF0F0_1234, 32'h0FF0_FF00},
            '{4'h1, 32'hF0F0_1234, 32'h0FF0_FF00},
            '{4'h7, 32'hF0F0_1234, 32'h0FF0_FF00},
            '{4'h3, 32'h0000_00C3, 32'hFFFF_FFE7},
            '{4'h5, 32'h8000_00C3, 32'h0000_0021},
            '{4'hA, 32'h1234_5678, 32'h0000_0000},
            '{4'hB, 32'h1234_5678, 32'h0F00_0000}
        };
        int   lat;
        obs_t obs, exp_v;
        bit   rs;
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            wait_out(lat, obs, rs);
            exp_v = pop_exp();
            n_tests++;
            if (lat != 1) begin
                n_fail++;
                $display("FAIL single_latency[%0d] op=%h got %0d want 1", i, vecs[i].op, lat);
            end
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_result[%0d] op=%h got %h want %h", i, vecs[i].op, obs, exp_v);
            end
            retire();
        end
    endtask

    task automatic test_mul();
        int   lat;
        obs_t obs, exp_v;
        bit   rs;
        send(4'h6, 32'h0001_0003, 32'h0000_0005, 1'b1);
        wait_out(lat, obs, rs);
        exp_v = pop_exp();
        n_tests++;
        if (lat != 33 || rs) begin
            n_fail++;
            $display("FAIL mul_latency got lat=%0d ready_seen=%b want lat=33 ready_seen=0", lat, rs);
        end
        n_tests++;
        if (obs !== exp_v || res !== 32'h0005_000F) begin
            n_fail++;
            $display("FAIL mul_result got %h want %h (res 0005000f)", obs, exp_v);
        end
        retire();
    endtask

    task automatic test_div();
        vec_t vecs[8] = '{
            '{4'hC, 32'd100, 32'd7},
            '{4'hD, 32'd100, 32'd7},
            '{4'hC, 32'hDEAD_BEEF, 32'd0},
            '{4'hD, 32'd9, 32'd0},
            '{4'hC, 32'hFFFF_FFFF, 32'h0001_0001},
            '{4'hD, 32'hFFFF_FFFF, 32'h8000_0001},
            '{4'h6, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{4'hD, 32'h0000_0003, 32'h0000_0003}
        };
        int   lat;
        obs_t obs, exp_v;
        bit   rs;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            wait_out(lat, obs, rs);
            exp_v = pop_exp();
            n_tests++;
            if (lat != 33 || obs !== exp_v) begin
                n_fail++;
                $display("FAIL div_case[%0d] op=%h got lat=%0d %h want lat=33 %h",
                         i, vecs[i].op, lat, obs, exp_v);
            end
            retire();
        end
    endtask

    task automatic test_hold();
        int   lat;
        obs_t obs, exp_v, held;
        bit   rs;
        send(4'h4, 32'd3, 32'd10, 1'b1);
        wait_out(lat, held, rs);
        exp_v = pop_exp();
        n_tests++;
        if (held !== exp_v) begin
            n_fail++;
            $display("FAIL hold_first got %h want %h", held, exp_v);
        end
        alu_ctrl = 4'h7;
        in1      = 32'hAAAA_0000;
        in2      = 32'h0000_5555;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            obs = {res, z_flg, n_flg, c_flg, v_flg, err};
            n_tests++;
            if ({out_valid, in_ready, obs} !== {2'b10, held}) begin
                n_fail++;
                $display("FAIL hold_stable[%0d] got ov=%b rdy=%b %h want ov=1 rdy=0 %h",
                         i, out_valid, in_ready, obs, held);
            end
        end
        sb.push_back(model(4'h7, 32'hAAAA_0000, 32'h0000_5555));
        retire();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_release got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat, obs, rs);
        exp_v = pop_exp();
        n_tests++;
        if (lat != 1 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL hold_next_req got lat=%0d %h want lat=1 %h", lat, obs, exp_v);
        end
        retire();
    endtask

    task automatic test_flush();
        int   lat;
        int   bad;
        obs_t obs, exp_v;
        bit   rs;
        send(4'h6, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_idle got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL flush_no_result got %0d out_valid cycles want 0", bad);
        end
        @(negedge clk);
        alu_ctrl = 4'h2;
        in1      = 32'd1;
        in2      = 32'd1;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_blocks_accept got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
        end
        send(4'h2, 32'd40, 32'd2, 1'b1);
        wait_out(lat, obs, rs);
        exp_v = pop_exp();
        n_tests++;
        if (lat != 1 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL flush_recover got lat=%0d %h want lat=1 %h", lat, obs, exp_v);
        end
        retire();
    endtask

    task automatic test_rst_mid();
        int   lat;
        obs_t obs, exp_v;
        bit   rs;
        send(4'h2, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_out(lat, obs, rs);
        exp_v = pop_exp();
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rst_pre_add got %h want %h", obs, exp_v);
        end
        retire();
        send(4'hC, 32'd1000, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, out_valid, res, z_flg, n_flg, c_flg, v_flg, err} !== {2'b10, 37'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_div got rdy=%b ov=%b res=%h flags=%b%b%b%b err=%b want rdy=1 ov=0 all 0",
                     in_ready, out_valid, res, z_flg, n_flg, c_flg, v_flg, err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(4'hC, 32'd1000, 32'd3, 1'b1);
        wait_out(lat, obs, rs);
        exp_v = pop_exp();
        n_tests++;
        if (lat != 33 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL rst_recover_div got lat=%0d %h want lat=33 %h", lat, obs, exp_v);
        end
        retire();
    endtask

    task automatic test_illegal();
        int   lat;
        obs_t obs, exp_v;
        bit   rs;
        send(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_out(lat, obs, rs);
        exp_v = pop_exp();
        n_tests++;
        if (lat != 1 || obs !== exp_v || err !== 1'b1 || res !== 32'd0) begin
            n_fail++;
            $display("FAIL illegal_op got lat=%0d %h want lat=1 %h", lat, obs, exp_v);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        logic [3:0]  op;
        logic [31:0] a, b;
        obs_t obs, exp_v;
        out_ready = 1'b1;
        while (got < 10 && cyc < 600) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                if (sent < 10) begin
                    op = 4'($urandom_range(0, 15));
                    a  = $urandom;
                    b  = (sent == 3) ? 32'd0 : $urandom;
                    alu_ctrl = op;
                    in1      = a;
                    in2      = b;
                    in_valid = 1'b1;
                    sb.push_back(model(op, a, b));
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid === 1'b1) begin
                obs   = {res, z_flg, n_flg, c_flg, v_flg, err};
                exp_v = pop_exp();
                n_tests++;
                if (obs !== exp_v || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d] got rdy=%b %h want rdy=0 %h", got, in_ready, obs, exp_v);
                end
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (got != 10 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count got %0d results, %0d pending want 10 results, 0 pending",
                     got, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_hold();
        test_flush();
        test_rst_mid();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
